// File: rtl/data_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_sync_pkg
// Purpose  : Types and defaults shared by the data_sync transmitter/receiver.
// Revision : 1.0 - initial release
// ============================================================================
package data_sync_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      RELEASE = 2'd2
   } tx_state_e;

   localparam int DEFAULT_BUS_WIDTH  = 8;
   localparam int DEFAULT_NUM_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
// Module   : bit_sync
// Purpose  : Multi-flop single-bit synchronizer, async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module bit_sync
   import data_sync_pkg::*;
#(
   parameter int NUM_STAGES = DEFAULT_NUM_STAGES
)(
   input  logic CLK,
   input  logic RST,
   input  logic d,
   output logic q
);

   logic [NUM_STAGES-1:0] r_sync;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[NUM_STAGES-2:0], d};
      end
   end

   assign q = r_sync[NUM_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/data_sync_tx.sv
`default_nettype none
// ============================================================================
// Module   : data_sync_tx
// Purpose  : Source-side 4-phase req/ack transmitter for the bus synchronizer.
//            Optional ack timeout enabled by macro DATA_SYNC_TX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module data_sync_tx
   import data_sync_pkg::*;
#(
   parameter int BUS_WIDTH      = DEFAULT_BUS_WIDTH,
   parameter int NUM_STAGES     = DEFAULT_NUM_STAGES,
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [BUS_WIDTH-1:0] unsync_bus,
   output logic                 bus_enable,
   input  logic                 bus_ack,
   output logic                 busy,
   output logic                 err_timeout
);

   tx_state_e            r_state;
   tx_state_e            w_state_nxt;
   logic [BUS_WIDTH-1:0] r_bus;
   logic [BUS_WIDTH-1:0] w_bus_nxt;
   logic                 r_en;
   logic                 w_en_nxt;
   logic                 w_ack_s;
   logic                 w_accept;
   logic                 w_tmo;

   bit_sync #(
      .NUM_STAGES (NUM_STAGES)
   ) u_ack_sync (
      .CLK (CLK),
      .RST (RST),
      .d   (bus_ack),
      .q   (w_ack_s)
   );

   // A stale ack left high by a source-only reset blocks new requests.
   assign in_ready   = (r_state == IDLE) && !w_ack_s;
   assign w_accept   = in_valid && in_ready;
   assign busy       = (r_state != IDLE);
   assign unsync_bus = r_bus;
   assign bus_enable = r_en;

`ifdef DATA_SYNC_TX_TIMEOUT_EN
   localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_TMO   = c_CNT_W'(TIMEOUT_CYCLES);

   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_inc;
   logic               r_err;

   assign w_cnt_inc = (r_cnt == c_TMO) ? r_cnt : r_cnt + 1'b1;
   assign w_tmo     = (r_state == REQ) && (w_cnt_inc == c_TMO);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_err <= w_tmo && !w_ack_s;
         if (w_accept) begin
            r_cnt <= '0;
         end else if (r_state == REQ) begin
            r_cnt <= w_cnt_inc;
         end
      end
   end

   assign err_timeout = r_err;
`else
   logic w_unused_tmo;

   assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
   assign w_tmo        = 1'b0;
   assign err_timeout  = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_en_nxt    = r_en;
      w_bus_nxt   = r_bus;
      case (r_state)
         IDLE: begin
            // Data and enable load on the same edge so data settles first.
            if (w_accept) begin
               w_bus_nxt   = in_data;
               w_en_nxt    = 1'b1;
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            w_en_nxt = 1'b1;
            if (w_ack_s || w_tmo) begin
               w_en_nxt    = 1'b0;
               w_state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            w_en_nxt = 1'b0;
            if (!w_ack_s) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_en_nxt    = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= IDLE;
         r_bus   <= '0;
         r_en    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_bus   <= w_bus_nxt;
         r_en    <= w_en_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_sync_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_sync_tx
// Purpose  : Scoreboard bench for data_sync_tx with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_sync_tx;

   localparam int BW  = 8;
   localparam int NS  = 2;
   localparam int TMO = 10;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [BW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [BW-1:0] unsync_bus;
   logic          bus_enable;
   logic          bus_ack;
   logic          busy;
   logic          err_timeout;

   int            n_vec = 0;
   int            n_err = 0;
   int            n_rise = 0;
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] last_word = '0;
   logic          prev_en = 1'b0;
   logic          force_mode = 1'b1;
   logic          force_val = 1'b0;
   logic [2:0]    r_dly = '0;

   data_sync_tx #(
      .BUS_WIDTH      (BW),
      .NUM_STAGES     (NS),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .unsync_bus  (unsync_bus),
      .bus_enable  (bus_enable),
      .bus_ack     (bus_ack),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   always #5 CLK = ~CLK;

   // Destination model: ack is bus_enable delayed by three CLK cycles.
   always @(posedge CLK) r_dly <= {r_dly[1:0], bus_enable};
   assign bus_ack = force_mode ? force_val : r_dly[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every new request must carry the next expected word.
   always @(negedge CLK) begin
      if (bus_enable && !prev_en) begin
         n_rise++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_req: got request with bus %0h, expected none", unsync_bus);
         end else begin
            check("req_data", 32'(unsync_bus), 32'(exp_q.pop_front()));
         end
      end
      prev_en = bus_enable;
   end

   // Called at a negedge; returns at the negedge following the accept edge.
   task automatic send(input logic [BW-1:0] w);
      int t = 0;
      in_data  = w;
      in_valid = 1'b1;
      while (!in_ready && t < 200) begin
         if (busy) check("hold_bus", 32'(unsync_bus), 32'(last_word));
         @(negedge CLK);
         t++;
      end
      check("accept_in_time", 32'(t < 200), 32'd1);
      exp_q.push_back(w);
      last_word = w;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!in_ready && t < 200) begin
         @(negedge CLK);
         t++;
      end
      check("idle_in_time", 32'(t < 200), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int r0;
      // Reset state
      repeat (3) @(negedge CLK);
      check("rst_en", 32'(bus_enable), 32'd0);
      RST = 1'b1;
      @(negedge CLK);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_en_rel", 32'(bus_enable), 32'd0);
      check("rst_bus", 32'(unsync_bus), 32'd0);
      check("rst_err", 32'(err_timeout), 32'd0);

      // Single transfer with loopback; k counts cycles after the accept edge
      force_mode = 1'b0;
      send(8'hA5);
      in_valid = 1'b0;
      for (int k = 0; k <= 12; k++) begin
         if (k > 0) @(negedge CLK);
         check("a5_en", 32'(bus_enable), 32'(k < 6));
         check("a5_ready", 32'(in_ready), 32'(k >= 12));
         check("a5_busy", 32'(busy), 32'(k < 12));
         check("a5_bus", 32'(unsync_bus), 32'hA5);
      end
      repeat (4) @(negedge CLK);

      // Back-to-back with in_valid held high
      r0 = n_rise;
      send(8'h01);
      send(8'h02);
      send(8'h03);
      in_valid = 1'b0;
      wait_idle();
      repeat (5) @(negedge CLK);
      check("b2b_rises", 32'(n_rise - r0), 32'd3);
      check("b2b_bus", 32'(unsync_bus), 32'h03);

      // Stale ack in IDLE blocks acceptance
      force_mode = 1'b1;
      force_val  = 1'b1;
      repeat (3) @(negedge CLK);
      in_data  = 8'h3C;
      in_valid = 1'b1;
      exp_q.push_back(8'h3C);
      repeat (4) begin
         @(negedge CLK);
         check("stale_en", 32'(bus_enable), 32'd0);
         check("stale_ready", 32'(in_ready), 32'd0);
      end
      force_val = 1'b0;
      @(negedge CLK);
      check("stale_ready_n1", 32'(in_ready), 32'd0);
      @(negedge CLK);
      check("stale_ready_n2", 32'(in_ready), 32'd1);
      check("stale_en_n2", 32'(bus_enable), 32'd0);
      @(negedge CLK);
      check("stale_en_n3", 32'(bus_enable), 32'd1);
      check("stale_bus_n3", 32'(unsync_bus), 32'h3C);
      in_valid   = 1'b0;
      force_mode = 1'b0;
      wait_idle();
      repeat (5) @(negedge CLK);

      // Reset asserted mid-transfer in REQ
      force_mode = 1'b1;
      force_val  = 1'b0;
      send(8'h77);
      in_valid = 1'b0;
      repeat (2) @(negedge CLK);
      check("mid_en_pre", 32'(bus_enable), 32'd1);
      force_val = 1'b1;
      #1 RST = 1'b0;
      #1;
      check("mid_en_async", 32'(bus_enable), 32'd0);
      check("mid_bus_async", 32'(unsync_bus), 32'd0);
      check("mid_busy_async", 32'(busy), 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      check("mid_ready_stale", 32'(in_ready), 32'd0);
      check("mid_en_stale", 32'(bus_enable), 32'd0);
      force_val = 1'b0;
      @(negedge CLK);
      check("mid_ready_n1", 32'(in_ready), 32'd0);
      @(negedge CLK);
      check("mid_ready_n2", 32'(in_ready), 32'd1);
      repeat (2) @(negedge CLK);

      // Ack never returns
      force_mode = 1'b1;
      force_val  = 1'b0;
      send(8'h5A);
      in_valid = 1'b0;
`ifdef DATA_SYNC_TX_TIMEOUT_EN
      for (int k = 0; k <= 12; k++) begin
         if (k > 0) @(negedge CLK);
         check("tmo_en", 32'(bus_enable), 32'(k < 10));
         check("tmo_err", 32'(err_timeout), 32'(k == 10));
         check("tmo_ready", 32'(in_ready), 32'(k >= 11));
      end
`else
      for (int k = 0; k < 30; k++) begin
         if (k > 0) @(negedge CLK);
         check("hang_en", 32'(bus_enable), 32'd1);
         check("hang_err", 32'(err_timeout), 32'd0);
      end
      force_mode = 1'b0;
      wait_idle();
`endif
      repeat (5) @(negedge CLK);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
